// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the RV32I core in reset, streams a length-prefixed image
// into instruction memory word by word, then releases the core to fetch from PC 0.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              boot_req_i,
  input  logic              run_req_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] ST_HOLD = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;
  localparam logic [2:0] ST_RUN  = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_W     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_W    = {ADDR_W{1'b0}};

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_lo_q, n_lo_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [23:0]       asm_q, asm_d;

  logic              s_ready_q, s_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer_s;
  logic [15:0]       n_full_s;
  logic              hdr_bad_s;

  assign xfer_s    = s_valid_i & s_ready_q;
  assign n_full_s  = {s_data_i, n_lo_q};
  // The count is widened so 2**ADDR_W itself is representable and legal.
  assign hdr_bad_s = (n_full_s == 16'd0) || ({1'b0, n_full_s} > MAX_WORDS);

  // Next-state, header capture, word assembly and write strobe generation
  always_comb begin
    state_d      = state_q;
    n_lo_d       = n_lo_q;
    last_d       = last_q;
    word_d       = word_q;
    byte_d       = byte_q;
    asm_d        = asm_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (boot_req_i) begin
      // Restart wins over everything, including a byte accepted this cycle.
      state_d = ST_HDR0;
      word_d  = ZERO_W;
      byte_d  = 2'd0;
      asm_d   = 24'd0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (run_req_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_HDR0: begin
          if (xfer_s) begin
            n_lo_d  = s_data_i;
            state_d = ST_HDR1;
          end else begin
            state_d = ST_HDR0;
          end
        end
        ST_HDR1: begin
          if (xfer_s) begin
            if (hdr_bad_s) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_DATA;
              last_d  = ADDR_W'(n_full_s - 16'd1);
              word_d  = ZERO_W;
              byte_d  = 2'd0;
              asm_d   = 24'd0;
            end
          end else begin
            state_d = ST_HDR1;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            byte_d = byte_q + 2'd1;
            asm_d  = {s_data_i, asm_q[23:8]};
            if (byte_q == 2'd3) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_q;
              imem_wdata_d = {s_data_i, asm_q};
              if (word_q == last_q) begin
                state_d = ST_FIN;
              end else begin
                word_d = word_q + ONE_W;
              end
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_FIN:  state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // Moore outputs are decoded from the next state so they register with it
  always_comb begin
    s_ready_d   = (state_d == ST_HDR0) || (state_d == ST_HDR1) || (state_d == ST_DATA);
    busy_d      = s_ready_d || (state_d == ST_FIN);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_q == ST_FIN) && (state_d == ST_RUN);
    err_d       = (state_d == ST_ERR);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_HOLD;
      n_lo_q       <= 8'd0;
      last_q       <= ZERO_W;
      word_q       <= ZERO_W;
      byte_q       <= 2'd0;
      asm_q        <= 24'd0;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= ZERO_W;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_lo_q       <= n_lo_d;
      last_q       <= last_d;
      word_q       <= word_d;
      byte_q       <= byte_d;
      asm_q        <= asm_d;
      s_ready_q    <= s_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign s_ready_o    = s_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: per-cycle vector table plus
// hand-written sequences for gaps, header errors, full-size image, abort and reset.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;

  logic              clk, reset;
  logic              boot_req, run_req, s_valid;
  logic [7:0]        s_data;
  logic              s_ready, imem_we, cpu_reset, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset), .boot_req_i(boot_req), .run_req_i(run_req),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_reset_o(cpu_reset), .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic boot, run, valid; logic [7:0] data;
    logic rdy, we; logic [7:0] addr; logic [31:0] wdata;
    logic crst, bsy, dn, er;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic b, logic r, logic v, logic [7:0] d, logic rdy, logic we,
                              logic [7:0] a, logic [31:0] wd, logic crst, logic bsy,
                              logic dn, logic er);
    vec_t t;
    t.boot = b; t.run = r; t.valid = v; t.data = d; t.rdy = rdy; t.we = we;
    t.addr = a; t.wdata = wd; t.crst = crst; t.bsy = bsy; t.dn = dn; t.er = er;
    return t;
  endfunction

  // Write/done monitor, sampled 1 time unit after each rising edge
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                done_cnt = 0;
  int                rst_early = 0;
  bit                mon_rst_chk = 1'b0;
  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (mon_rst_chk && done_cnt == 0 && !done && !cpu_reset) rst_early++;
    if (done) done_cnt++;
  end

  task automatic clr_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt  = 0;
    rst_early = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [45:0] outs();
    return {s_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err};
  endfunction

  task automatic apply(input int idx);
    vec_t v;
    logic ok;
    v = tbl[idx];
    @(negedge clk);
    boot_req = v.boot; run_req = v.run; s_valid = v.valid; s_data = v.data;
    @(posedge clk);
    #1;
    ok = (s_ready === v.rdy) && (imem_we === v.we) && (cpu_reset === v.crst) &&
         (busy === v.bsy) && (done === v.dn) && (err === v.er) &&
         (!v.we || ((imem_addr === v.addr) && (imem_wdata === v.wdata)));
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL vec%0d: got rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b; want rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b",
               idx, s_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err,
               v.rdy, v.we, v.addr, v.wdata, v.crst, v.bsy, v.dn, v.er);
    end
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
    @(negedge clk);
    boot_req = 1'b0; run_req = 1'b0; s_valid = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte: s_ready stayed %b, required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  task automatic pulse_boot();
    @(negedge clk);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(name, done_cnt, 1);
  endtask

  function automatic logic [31:0] f256(int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb ^ 8'h5A, ~kb, kb, 8'hC3};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] img1[$];
    logic [7:0] img[$];
    int bad;
    img1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    // Test 1: basic two-word image, cycle by cycle
    tbl.push_back(mk(1,0,0,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h02, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h13, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00, 1,1,8'h00,32'h0000_0013,  1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h93, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h10, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00, 0,1,8'h01,32'h0010_0093,  1,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,32'h0,          0,0,1,0));
    tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,32'h0,          0,0,0,0));
    // Test 6: run_req from HOLD, run_req ignored elsewhere, boot_req from RUN (idx 13..17)
    tbl.push_back(mk(0,1,0,8'h00, 0,0,8'h00,32'h0,          0,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,32'h0,          0,0,0,0));
    tbl.push_back(mk(0,1,0,8'h00, 0,0,8'h00,32'h0,          0,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));
    tbl.push_back(mk(0,1,0,8'h00, 1,0,8'h00,32'h0,          1,1,0,0));

    reset = 1'b1; boot_req = 1'b0; run_req = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    run_tbl(0, 12);

    // Test 2: same image with random valid gaps
    clr_mon();
    pulse_boot();
    mon_rst_chk = 1'b1;
    send_image(img1, 3);
    wait_done("t2_done_once");
    mon_rst_chk = 1'b0;
    chk("t2_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("t2_w0", {wr_addr[0], wr_data[0]}, {8'h00, 32'h0000_0013});
      chk("t2_w1", {wr_addr[1], wr_data[1]}, {8'h01, 32'h0010_0093});
    end
    chk("t2_cpu_reset_before_done", rst_early, 0);

    // Test 3: zero-length header -> ERR, then recovery
    clr_mon();
    pulse_boot();
    send_image('{8'h00, 8'h00}, 0);
    chk("t3_err_state", {err, s_ready, cpu_reset, busy}, {1'b1, 1'b0, 1'b1, 1'b0});
    s_valid = 1'b1; s_data = 8'h55; run_req = 1'b1;
    repeat (2) @(negedge clk);
    s_valid = 1'b0; run_req = 1'b0;
    chk("t3_err_held", {err, s_ready, cpu_reset}, {1'b1, 1'b0, 1'b1});
    chk("t3_no_writes", wr_addr.size(), 0);
    pulse_boot();
    chk("t3_err_cleared", {err, busy, s_ready}, {1'b0, 1'b1, 1'b1});
    send_image(img1, 0);
    wait_done("t3_done");
    chk("t3_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) chk("t3_w1", {wr_addr[1], wr_data[1]}, {8'h01, 32'h0010_0093});

    // Test 4: N=257 rejected, N=256 fills the whole memory
    clr_mon();
    pulse_boot();
    send_image('{8'h01, 8'h01}, 0);
    chk("t4_n257_err", err, 1'b1);
    pulse_boot();
    img = '{8'h00, 8'h01};
    for (int k = 0; k < 256; k++) begin
      img.push_back(f256(k)[7:0]);
      img.push_back(f256(k)[15:8]);
      img.push_back(f256(k)[23:16]);
      img.push_back(f256(k)[31:24]);
    end
    send_image(img, 0);
    wait_done("t4_done");
    chk("t4_nwrites", wr_addr.size(), 256);
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] !== 8'(i) || wr_data[i] !== f256(i)) bad++;
    chk("t4_bad_words", bad, 0);
    if (wr_addr.size() > 0) chk("t4_last_addr", wr_addr[wr_addr.size()-1], 8'hFF);

    // Test 5a: restart after 6 data bytes; byte taken with boot_req is dropped
    clr_mon();
    pulse_boot();
    send_image('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 0);
    boot_req = 1'b1; s_valid = 1'b1; s_data = 8'h05;
    @(negedge clk);
    boot_req = 1'b0; s_valid = 1'b0;
    send_image(img1, 0);
    wait_done("t5_done");
    chk("t5_nwrites", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      chk("t5_w_aborted0", {wr_addr[0], wr_data[0]}, {8'h00, 32'h4433_2211});
      chk("t5_w_new0", {wr_addr[1], wr_data[1]}, {8'h00, 32'h0000_0013});
      chk("t5_w_new1", {wr_addr[2], wr_data[2]}, {8'h01, 32'h0010_0093});
    end

    // Test 5b: asynchronous reset mid-DATA
    pulse_boot();
    send_image('{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF}, 0);
    clr_mon();
    s_valid = 1'b1; s_data = 8'h77;
    #2 reset = 1'b1;
    #1 chk("t5_async_reset", outs(), {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("t5_after_reset", {s_ready, busy, cpu_reset, done}, {1'b0, 1'b0, 1'b1, 1'b0});
    chk("t5_no_writes", wr_addr.size(), 0);

    // Test 6
    clr_mon();
    run_tbl(13, 17);
    chk("t6_no_writes", wr_addr.size(), 0);
    chk("t6_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
